// File: rtl/spi_rx_pkg.sv
// Shared constants, edge-select encoding and the masked frame compare for spi_rx.
package spi_rx_pkg;

  localparam int FRAME_W     = 16;
  localparam int BYTE_W      = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic {
    EDG_FALL = 1'b0,
    EDG_RISE = 1'b1
  } edg_e;

  // In byte mode the upper half of shft/match/mask never influences the result.
  function automatic logic frame_hit(input logic [FRAME_W-1:0] shft,
                                     input logic [FRAME_W-1:0] match,
                                     input logic [FRAME_W-1:0] mask,
                                     input logic               len8);
    logic [FRAME_W-1:0] diff;
    diff = (shft ^ match) & ~mask;
    if (len8) return (diff[BYTE_W-1:0] == '0);
    return (diff == '0);
  endfunction

endpackage

// File: rtl/spi_rx_sync.sv
// Two-flop synchronizer plus a previous-value flop for edge detection.
// All flops reset to 1 so an idle-high bus produces no edge at reset release.
module spi_rx_sync
  import spi_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_rx.sv
// SPI slave receiver with masked-pattern trigger on end of frame.
// Optional bit-count qualification is enabled by defining SPI_RX_LEN_CHECK_EN.
module spi_rx
  import spi_rx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  input  logic               edg,
  input  logic               len8_16,
  input  logic [FRAME_W-1:0] mask,
  input  logic [FRAME_W-1:0] match,
  output logic               SPItrig
);

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  spi_rx_sync u_ss_sync   (.clk(clk), .rst(rst), .async_i(SS_n),
                           .sync_o(ss_sync), .rise_o(ss_rise), .fall_o(ss_fall));
  spi_rx_sync u_sclk_sync (.clk(clk), .rst(rst), .async_i(SCLK),
                           .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall));
  spi_rx_sync u_mosi_sync (.clk(clk), .rst(rst), .async_i(MOSI),
                           .sync_o(mosi_sync), .rise_o(mosi_rise), .fall_o(mosi_fall));

  logic unused_sigs;
  assign unused_sigs = ^{sclk_sync, mosi_rise, mosi_fall, ss_fall};

  logic               sample;
  logic [FRAME_W-1:0] shft_q, shft_d;
  logic               eof_q;
  logic               trig_q;
  logic               len_ok;

  assign sample = ~ss_sync & ((edg_e'(edg) == EDG_RISE) ? sclk_rise : sclk_fall);
  assign shft_d = sample ? {shft_q[FRAME_W-2:0], mosi_sync} : shft_q;

`ifdef SPI_RX_LEN_CHECK_EN
  logic [4:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = ss_fall ? 5'd0 : cnt_q;
    if (sample && cnt_d != 5'd31) cnt_d = cnt_d + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 5'd0;
    else     cnt_q <= cnt_d;
  end

  assign len_ok = (cnt_q == (len8_16 ? 5'd8 : 5'd16));
`else
  assign len_ok = 1'b1;
`endif

  // eof_q delays the compare one clk so a sample coinciding with SS_n rise lands first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shft_q <= '0;
      eof_q  <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      shft_q <= shft_d;
      eof_q  <= ss_rise;
      trig_q <= eof_q & len_ok & frame_hit(shft_q, match, mask, len8_16);
    end
  end

  assign SPItrig = trig_q;

endmodule

// File: tb/tb_spi_rx.sv
// Scoreboard bench for spi_rx: stimulus queues expected trigger cycles, a monitor pops them.
module tb_spi_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b1;
  logic        edg = 1'b1;
  logic        len8_16 = 1'b0;
  logic [15:0] mask = 16'h0000;
  logic [15:0] match = 16'h0000;
  logic        SPItrig;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int exp_q[$];

`ifdef SPI_RX_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  spi_rx dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .edg(edg), .len8_16(len8_16), .mask(mask), .match(match), .SPItrig(SPItrig)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every trigger pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && SPItrig) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL spurious_trig: SPItrig=1 at cycle %0d, required no trigger", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc != e) begin
          mismatched++;
          $display("FAIL trig_cycle: trigger at cycle %0d, required cycle %0d", cyc, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic setup_frame(input bit e, input bit l8, input logic [15:0] msk,
                             input logic [15:0] mt);
    @(negedge clk);
    edg = e; len8_16 = l8; mask = msk; match = mt; SCLK = ~e;
    repeat (4) @(negedge clk);
    SS_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [15:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      MOSI = data[i];
      SCLK = ~edg;
      repeat (4) @(negedge clk);
      SCLK = edg;
      repeat (4) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  // SS_n rises at a negedge; the fourth rising edge after that shows the pulse.
  task automatic end_frame(input bit exp_trig);
    SS_n = 1'b1;
    if (exp_trig) exp_q.push_back(cyc + 4);
    repeat (12) @(negedge clk);
  endtask

  task automatic send_frame(input bit e, input bit l8, input logic [15:0] msk,
                            input logic [15:0] mt, input logic [15:0] data,
                            input int nbits, input bit exp_trig);
    setup_frame(e, l8, msk, mt);
    shift_bits(data, nbits);
    end_frame(exp_trig);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_trig", {15'd0, SPItrig}, 16'h0000);
    chk("reset_ss_sync", {15'd0, dut.u_ss_sync.sync_o}, 16'h0001);
    chk("reset_sclk_sync", {15'd0, dut.u_sclk_sync.sync_o}, 16'h0001);
    chk("reset_mosi_sync", {15'd0, dut.u_mosi_sync.sync_o}, 16'h0001);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 16-bit rising edge, exact match
    send_frame(1'b1, 1'b0, 16'h0000, 16'h8123, 16'h8123, 16, 1'b1);
    // 16-bit falling edge, mismatching MSB masked
    send_frame(1'b0, 1'b0, 16'h8000, 16'h8123, 16'h0123, 16, 1'b1);
    // 8-bit hit, then 8-bit miss; shft becomes 0x2323 then 0x2311
    send_frame(1'b0, 1'b1, 16'h8000, 16'h8123, 16'h0023, 8, 1'b1);
    send_frame(1'b0, 1'b1, 16'h8000, 16'h8123, 16'h0011, 8, 1'b0);

    // SCLK activity with SS_n high must not disturb shft (still 0x2311)
    for (int i = 0; i < 16; i++) begin
      MOSI = i[0];
      SCLK = 1'b0;
      repeat (4) @(negedge clk);
      SCLK = 1'b1;
      repeat (4) @(negedge clk);
    end
    setup_frame(1'b0, 1'b0, 16'h0000, 16'h2311);
    end_frame(!LEN_CHK);

    // 16-bit single-bit miss, then all-masked frame
    send_frame(1'b1, 1'b0, 16'h0000, 16'hA5A5, 16'hA5A4, 16, 1'b0);
    send_frame(1'b1, 1'b0, 16'hFFFF, 16'h1234, 16'h3C3C, 16, 1'b1);

    // Reset mid-frame
    setup_frame(1'b1, 1'b0, 16'h0000, 16'h8123);
    shift_bits(16'h8123, 5);
    rst = 1'b1;
    #1;
    chk("midrst_trig", {15'd0, SPItrig}, 16'h0000);
    chk("midrst_ss_sync", {15'd0, dut.u_ss_sync.sync_o}, 16'h0001);
    chk("midrst_sclk_sync", {15'd0, dut.u_sclk_sync.sync_o}, 16'h0001);
    chk("midrst_mosi_sync", {15'd0, dut.u_mosi_sync.sync_o}, 16'h0001);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    end_frame(1'b0);

    // Truncated 4-bit frame after reset: shft = 0x0005 hits unless length is checked
    send_frame(1'b1, 1'b0, 16'hFFF0, 16'h0005, 16'h0005, 4, !LEN_CHK);

    repeat (20) @(negedge clk);
    chk("pending_triggers", exp_q.size(), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
